seq_bin_to_bcd: RTL

SEQ_BIN_TO_BCD -- requirements
Module: seq_bin_to_bcd

---
 rtl/seq_bin_to_bcd_if.sv | 12 +
 rtl/seq_bin_to_bcd.sv | 93 +++++++++
 2 files changed

// File: rtl/seq_bin_to_bcd_if.sv
// Conversion request/result bundle for seq_bin_to_bcd.
// Handshake: the master pulses start with bin valid. The slave accepts start only in IDLE or DONE, raises busy for the 16 conversion cycles, then pulses done for one cycle while bcd holds the new result.
interface seq_bin_to_bcd_if;
  logic        start;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic        busy;
  logic        done;

  modport master (output start, output bin, input bcd, input busy, input done);
  modport slave  (input start, input bin, output bcd, output busy, output done);
endinterface

// File: rtl/seq_bin_to_bcd.sv
// Sequential 16-bit binary to 5-digit BCD converter.
// Uses double-dabble, one bit per cycle, with a fixed 16-cycle latency.
module seq_bin_to_bcd (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_bin_to_bcd_if.slave        bus,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] scr_q, scr_d;
  logic [15:0] sh_q, sh_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [19:0] bcd_q, bcd_d;
  logic [19:0] adj;
  logic [19:0] scr_next;

  // Add-3 correction on every nibble before the shift keeps each digit within 0..9 after doubling.
  always_comb begin
    adj = '0;
    for (int i = 0; i < 5; i++) begin
      adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
    end
    scr_next = {adj[18:0], sh_q[15]};
  end

  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          sh_d    = bus.bin;
          scr_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        scr_d = scr_next;
        sh_d  = {sh_q[14:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = DONE;
          bcd_d   = scr_next;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = SHIFT;
          sh_d    = bus.bin;
          scr_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scr_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  // Status outputs decode straight from the state register, so an asynchronous reset clears them immediately.
  assign bus.bcd     = bcd_q;
  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule
